// File: rtl/wb_pkg.sv
// Shared types and default widths for the register write-back queue.
package wb_pkg;

  localparam int WB_ADDR_W = 6;
  localparam int WB_DATA_W = 32;
  localparam int REG_COUNT = 64;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer; exposes every slot plus a valid mask
// so the parent can search the buffered writes.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              push1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              pop,
  output logic [ADDR_W-1:0] ent_addr [DEPTH],
  output logic [DATA_W-1:0] ent_data [DEPTH],
  output logic [DEPTH-1:0]  ent_vld,
  output logic [PTR_W-1:0]  head,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tail_p1;

  assign tail_p1  = tail + PTR_W'(1);
  assign ent_addr = mem_addr;
  assign ent_data = mem_data;

  // Only pointers and occupancy are reset; payload slots are qualified by ent_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
      count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  // push1 is only ever raised together with push0, so it lands one slot behind.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_addr[tail] <= addr0;
      mem_data[tail] <= data0;
    end
    if (push1) begin
      mem_addr[tail_p1] <= addr1;
      mem_data[tail_p1] <= data1;
    end
  end

  always_comb begin
    ent_vld = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) ent_vld[head + PTR_W'(k)] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the register file: loads and ALU results in, one write per cycle out.
// Optional pending-write bypass lookup is built when WB_BYPASS_EN is defined.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int DROP_R0 = 0,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WD,
  output logic              RegWrite,
  output logic [CNT_W-1:0]  pending,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              qry_hit,
  output logic [DATA_W-1:0] qry_data
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              mem_keep, alu_keep;
  logic              push0, push1, pop;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  function automatic logic is_dropped(input logic [ADDR_W-1:0] rd);
    return (DROP_R0 != 0) && (rd == '0);
  endfunction

  // Readiness looks only at the registered count; a same-cycle pop never frees a slot.
  assign mem_ready = (count < FULL);
  assign alu_ready = (count < FULL - CNT_W'(1)) ||
                     ((count == FULL - CNT_W'(1)) && !mem_valid);

  assign mem_keep = mem_valid && mem_ready && !is_dropped(mem_rd);
  assign alu_keep = alu_valid && alu_ready && !is_dropped(alu_rd);

  // The load is the older instruction, so it takes the first free slot.
  assign push0 = mem_keep || alu_keep;
  assign push1 = mem_keep && alu_keep;
  assign addr0 = mem_keep ? mem_rd   : alu_rd;
  assign data0 = mem_keep ? mem_data : alu_data;
  assign pop   = (count != '0);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push0    (push0),
    .addr0    (addr0),
    .data0    (data0),
    .push1    (push1),
    .addr1    (alu_rd),
    .data1    (alu_data),
    .pop      (pop),
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .head     (head),
    .count    (count)
  );

  // Remembers the last issued write so WR/WD hold steady while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (pop) begin
      last_addr <= ent_addr[head];
      last_data <= ent_data[head];
    end
  end

  assign pending  = count;
  assign RegWrite = pop;
  assign WR       = pop ? ent_addr[head] : last_addr;
  assign WD       = pop ? ent_data[head] : last_data;

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    qry_hit  = 1'b0;
    qry_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[head + PTR_W'(k)] && (ent_addr[head + PTR_W'(k)] == qry_addr)) begin
        qry_hit  = 1'b1;
        qry_data = ent_data[head + PTR_W'(k)];
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{qry_addr, ent_vld};
  assign qry_hit       = 1'b0;
  assign qry_data      = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: two instances (DROP_R0=0 and DROP_R0=1) against a queue-based model.
module tb_reg_writeback_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;

  logic                 mem_valid [2];
  logic                 mem_ready [2];
  logic [WB_ADDR_W-1:0] mem_rd    [2];
  logic [WB_DATA_W-1:0] mem_data  [2];
  logic                 alu_valid [2];
  logic                 alu_ready [2];
  logic [WB_ADDR_W-1:0] alu_rd    [2];
  logic [WB_DATA_W-1:0] alu_data  [2];
  logic [WB_ADDR_W-1:0] wr        [2];
  logic [WB_DATA_W-1:0] wd        [2];
  logic                 regwrite  [2];
  logic [CNT_W-1:0]     pending   [2];
  logic                 qry_hit   [2];
  logic [WB_DATA_W-1:0] qry_data  [2];
  logic [WB_ADDR_W-1:0] qry_addr;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH), .DROP_R0(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_rd(mem_rd[0]), .mem_data(mem_data[0]),
    .alu_valid(alu_valid[0]), .alu_ready(alu_ready[0]), .alu_rd(alu_rd[0]), .alu_data(alu_data[0]),
    .WR(wr[0]), .WD(wd[0]), .RegWrite(regwrite[0]), .pending(pending[0]),
    .qry_addr(qry_addr), .qry_hit(qry_hit[0]), .qry_data(qry_data[0])
  );

  reg_writeback_queue #(.DEPTH(DEPTH), .DROP_R0(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_rd(mem_rd[1]), .mem_data(mem_data[1]),
    .alu_valid(alu_valid[1]), .alu_ready(alu_ready[1]), .alu_rd(alu_rd[1]), .alu_data(alu_data[1]),
    .WR(wr[1]), .WD(wd[1]), .RegWrite(regwrite[1]), .pending(pending[1]),
    .qry_addr(qry_addr), .qry_hit(qry_hit[1]), .qry_data(qry_data[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  wb_entry_t mq [2][$];
  wb_entry_t last_wr [2];
  bit        mem_acc [2];
  bit        alu_acc [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string s, input int i);
    return $sformatf("%s[%0d]", s, i);
  endfunction

  function automatic wb_entry_t mk(input logic [WB_ADDR_W-1:0] a, input logic [WB_DATA_W-1:0] d);
    wb_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic check_outputs(input int i);
    int        sz;
    int        free_slots;
    wb_entry_t e;
    bit        hit;
    logic [WB_DATA_W-1:0] hd;
    sz         = mq[i].size();
    free_slots = DEPTH - sz;
    e          = (sz != 0) ? mq[i][0] : last_wr[i];
    hit        = 1'b0;
    hd         = '0;
`ifdef WB_BYPASS_EN
    for (int k = 0; k < sz; k++) begin
      if (mq[i][k].addr == qry_addr) begin
        hit = 1'b1;
        hd  = mq[i][k].data;
      end
    end
`endif
    check_eq(tg("pending", i),   64'(pending[i]),   64'(sz));
    check_eq(tg("regwrite", i),  64'(regwrite[i]),  64'(sz != 0));
    check_eq(tg("wr", i),        64'(wr[i]),        64'(e.addr));
    check_eq(tg("wd", i),        64'(wd[i]),        64'(e.data));
    check_eq(tg("mem_ready", i), 64'(mem_ready[i]), 64'(free_slots >= 1));
    check_eq(tg("alu_ready", i), 64'(alu_ready[i]),
             64'((free_slots >= 2) || (free_slots == 1 && !mem_valid[i])));
    check_eq(tg("qry_hit", i),   64'(qry_hit[i]),   64'(hit));
    check_eq(tg("qry_data", i),  64'(qry_data[i]),  64'(hd));
  endtask

  task automatic decide(input int i);
    int sz;
    sz = mq[i].size();
    mem_acc[i] = mem_valid[i] && (sz < DEPTH);
    alu_acc[i] = alu_valid[i] && ((sz <= DEPTH - 2) || (sz == DEPTH - 1 && !mem_valid[i]));
  endtask

  task automatic commit(input int i);
    if (mq[i].size() != 0) last_wr[i] = mq[i].pop_front();
    if (mem_acc[i] && !(i == 1 && mem_rd[i] == '0)) mq[i].push_back(mk(mem_rd[i], mem_data[i]));
    if (alu_acc[i] && !(i == 1 && alu_rd[i] == '0)) mq[i].push_back(mk(alu_rd[i], alu_data[i]));
  endtask

  // Entered and left on a falling edge; inputs are already applied by the caller.
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      decide(i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) commit(i);
    @(negedge clk);
  endtask

  task automatic drive_same(input logic mv, input logic [WB_ADDR_W-1:0] mr, input logic [WB_DATA_W-1:0] md,
                            input logic av, input logic [WB_ADDR_W-1:0] ar, input logic [WB_DATA_W-1:0] ad);
    for (int i = 0; i < 2; i++) begin
      mem_valid[i] = mv; mem_rd[i] = mr; mem_data[i] = md;
      alu_valid[i] = av; alu_rd[i] = ar; alu_data[i] = ad;
    end
  endtask

  // A request refused last edge is held unchanged; otherwise a fresh one is drawn.
  task automatic drive_random(input int pct);
    for (int i = 0; i < 2; i++) begin
      if (!(mem_valid[i] && !mem_acc[i])) begin
        mem_valid[i] = ($urandom_range(0, 99) < pct);
        mem_rd[i]    = WB_ADDR_W'($urandom_range(0, 15));
        mem_data[i]  = $urandom;
      end
      if (!(alu_valid[i] && !alu_acc[i])) begin
        alu_valid[i] = ($urandom_range(0, 99) < pct);
        alu_rd[i]    = WB_ADDR_W'($urandom_range(0, 15));
        alu_data[i]  = $urandom;
      end
    end
    qry_addr = WB_ADDR_W'($urandom_range(0, 15));
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq(tg("arst_pending", i),  64'(pending[i]),  64'(0));
      check_eq(tg("arst_regwrite", i), 64'(regwrite[i]), 64'(0));
      check_eq(tg("arst_wr", i),       64'(wr[i]),       64'(0));
      check_eq(tg("arst_wd", i),       64'(wd[i]),       64'(0));
      mq[i].delete();
      last_wr[i] = '0;
      mem_acc[i] = 1'b0;
      alu_acc[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pcts [6] = '{20, 50, 80, 100, 35, 65};
    rst_n    = 1'b0;
    qry_addr = '0;
    drive_same(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) last_wr[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq(tg("rst_pending", i),  64'(pending[i]),  64'(0));
      check_eq(tg("rst_regwrite", i), 64'(regwrite[i]), 64'(0));
      check_eq(tg("rst_wr", i),       64'(wr[i]),       64'(0));
      check_eq(tg("rst_wd", i),       64'(wd[i]),       64'(0));
      check_eq(tg("rst_qry_hit", i),  64'(qry_hit[i]),  64'(0));
      check_eq(tg("rst_qry_data", i), 64'(qry_data[i]), 64'(0));
    end
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 2; i++) begin
      check_eq(tg("idle_mem_ready", i), 64'(mem_ready[i]), 64'(1));
      check_eq(tg("idle_alu_ready", i), 64'(alu_ready[i]), 64'(1));
    end

    // Single ALU result
    drive_same(0, 0, 0, 1, 6'd5, 32'hDEADBEEF);
    cycle();
    drive_same(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      check_eq(tg("single_regwrite", i), 64'(regwrite[i]), 64'(1));
      check_eq(tg("single_wr", i),       64'(wr[i]),       64'(5));
      check_eq(tg("single_wd", i),       64'(wd[i]),       64'(32'hDEADBEEF));
    end
    cycle();
    check_eq("single_drained", 64'(pending[0]), 64'(0));

    // Load and ALU to the same register in one cycle
    drive_same(1, 6'd3, 32'h11, 1, 6'd3, 32'h22);
    cycle();
    drive_same(0, 0, 0, 0, 0, 0);
    check_eq("dual_first_wd", 64'(wd[0]), 64'(32'h11));
    cycle();
    check_eq("dual_second_wd", 64'(wd[0]), 64'(32'h22));
    cycle();
    check_eq("dual_final_regwrite", 64'(regwrite[0]), 64'(0));
    check_eq("dual_final_wd",       64'(wd[0]),       64'(32'h22));

    // Back-pressure with both producers always valid
    for (int c = 0; c < 6; c++) begin
      drive_random(100);
      #1;
      if (mq[0].size() == DEPTH - 1 && mem_valid[0] && alu_valid[0]) begin
        check_eq("bp_alu_ready", 64'(alu_ready[0]), 64'(0));
        check_eq("bp_mem_ready", 64'(mem_ready[0]), 64'(1));
      end
      cycle();
    end
    check_eq("bp_pending", 64'(pending[0]), 64'(DEPTH - 1));
    repeat (6) begin
      drive_random(0);
      cycle();
    end

    // Two buffered writes to r7; youngest must win the lookup
    drive_same(1, 6'd7, 32'hA, 1, 6'd7, 32'hB);
    qry_addr = 6'd8;
    cycle();
    drive_same(0, 0, 0, 0, 0, 0);
    qry_addr = 6'd7;
    #1;
`ifdef WB_BYPASS_EN
    check_eq("byp_hit7",  64'(qry_hit[0]),  64'(1));
    check_eq("byp_data7", 64'(qry_data[0]), 64'(32'hB));
`else
    check_eq("byp_hit7",  64'(qry_hit[0]),  64'(0));
    check_eq("byp_data7", 64'(qry_data[0]), 64'(0));
`endif
    qry_addr = 6'd8;
    #1;
    check_eq("byp_hit8", 64'(qry_hit[0]), 64'(0));
    qry_addr = 6'd7;
    repeat (3) cycle();

    // Asynchronous reset with three writes buffered
    drive_same(1, 6'd9, 32'h1, 1, 6'd10, 32'h2);
    cycle();
    drive_same(1, 6'd11, 32'h3, 1, 6'd12, 32'h4);
    cycle();
    drive_same(0, 0, 0, 0, 0, 0);
    check_eq("pre_rst_pending", 64'(pending[0]), 64'(3));
    async_reset();
    cycle();

    // Writes to r0: kept by dut0, swallowed by dut1
    drive_same(1, 6'd0, 32'h44, 1, 6'd0, 32'h55);
    cycle();
    drive_same(0, 0, 0, 0, 0, 0);
    check_eq("r0_drop_pending",  64'(pending[1]),  64'(0));
    check_eq("r0_drop_regwrite", 64'(regwrite[1]), 64'(0));
    check_eq("r0_keep_pending",  64'(pending[0]),  64'(2));
    check_eq("r0_keep_wd",       64'(wd[0]),       64'(32'h44));
    repeat (3) cycle();

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 1500; c++) begin
      drive_random(pcts[(c / 250) % 6]);
      cycle();
      if ($urandom_range(0, 299) == 0) begin
        drive_same(0, 0, 0, 0, 0, 0);
        async_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
